// File: rtl/md_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_issue_ctrl_pkg
//  Purpose  : Shared HiLoOp encodings, shadow-FSM state type and small
//             classification helpers for the multiply/divide issue control.
//  Contents : HILO_W, *_OP encodings (NOP_OP = no HI/LO activity),
//             md_state_e, is_start_op(), is_mul_op()
//  Revision : 1.0  initial release
// ============================================================================
package md_issue_ctrl_pkg;

    localparam int HILO_W = 4;

    typedef logic [HILO_W-1:0] hilo_op_t;

    // HiLoOp encodings as carried down the pipeline. NOP_OP marks any
    // instruction that does not touch the HI/LO unit.
    localparam hilo_op_t NOP_OP   = 4'd0;
    localparam hilo_op_t MULT_OP  = 4'd1;
    localparam hilo_op_t MULTU_OP = 4'd2;
    localparam hilo_op_t DIV_OP   = 4'd3;
    localparam hilo_op_t DIVU_OP  = 4'd4;
    localparam hilo_op_t MFHI_OP  = 4'd5;
    localparam hilo_op_t MFLO_OP  = 4'd6;
    localparam hilo_op_t MTHI_OP  = 4'd7;
    localparam hilo_op_t MTLO_OP  = 4'd8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Ops that kick off a multi-cycle operation inside the unit.
    function automatic logic is_start_op(input hilo_op_t op);
        return (op == MULT_OP) || (op == MULTU_OP) ||
               (op == DIV_OP)  || (op == DIVU_OP);
    endfunction

    // Distinguishes the short (multiply) window from the long (divide) one.
    function automatic logic is_mul_op(input hilo_op_t op);
        return (op == MULT_OP) || (op == MULTU_OP);
    endfunction

endpackage : md_issue_ctrl_pkg
`default_nettype wire

// File: rtl/md_issue_ctrl_shadow_timer.sv
`default_nettype none
// ============================================================================
//  Module   : md_shadow_timer
//  Purpose  : Down-counter mirroring the multdiv busy window. Loads a nonzero
//             cycle count on a strobe, decrements on request, saturates at 0.
//  Ports    : clk, reset      clock, synchronous active-high reset
//             load_val_i      value loaded on load_i
//             load_i          load strobe (has priority over decrement)
//             dec_i           decrement request
//             cnt_o           current count
//             busy_o          count is nonzero
//  Revision : 1.0  initial release
// ============================================================================
module md_shadow_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             busy_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Never wraps: a decrement at zero holds zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign busy_o = (cnt_q != '0);

endmodule : md_shadow_timer
`default_nettype wire

// File: rtl/md_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : md_issue_ctrl
//  Purpose  : E-stage requester for the multiply/divide unit. Forwards the E
//             HiLoOp to multdiv, tracks the unit's busy window with a shadow
//             model, stalls D for HI/LO instructions while an op is in
//             flight, and flags disagreement between unit replies and the
//             shadow model.
//  Ports    : clk, reset      clock, synchronous active-high reset
//             d_hilo_op_i     HiLoOp of instruction in D
//             e_hilo_op_i     HiLoOp of instruction in E
//             e_flush_i       E instruction squashed this cycle
//             md_start_i      unit says E op is a start op
//             md_busy_i       unit busy flag
//             issue_op_o      HiLoOp driven into multdiv
//             stall_d_o       freeze F/D, bubble into E
//             md_pending_o    shadow model has an op in flight
//             proto_err_o     sticky protocol-violation flag
//  Revision : 1.0  initial release
// ============================================================================
module md_issue_ctrl
    import md_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [HILO_W-1:0] d_hilo_op_i,
    input  logic [HILO_W-1:0] e_hilo_op_i,
    input  logic              e_flush_i,
    input  logic              md_start_i,
    input  logic              md_busy_i,
    output logic [HILO_W-1:0] issue_op_o,
    output logic              stall_d_o,
    output logic              md_pending_o,
    output logic              proto_err_o
);

    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES);

    md_state_e        state_q;
    logic             proto_err_q;

    logic [CNT_W-1:0] w_cnt;
    logic             w_busy;
    logic             w_start_e;
    logic             w_pending;
    logic             w_last;
    logic             w_load;
    logic             w_dec;
    logic [CNT_W-1:0] w_load_val;
    logic             w_start_mismatch;
    logic             w_busy_mismatch;
    logic             w_start_in_run;

    // A flushed op (or anything during reset) never reaches the unit.
    assign issue_op_o = (reset || e_flush_i) ? NOP_OP : e_hilo_op_i;
    assign w_start_e  = is_start_op(issue_op_o);

    assign w_pending  = (state_q == ST_RUN);
    assign w_last     = (w_cnt == CNT_W'(1));

    // Any start op loads the timer; in RUN this is a restart that mirrors
    // the unit overwriting its own in-flight operation.
    assign w_load     = w_start_e;
    assign w_load_val = is_mul_op(issue_op_o) ? c_mul_load : c_div_load;
    assign w_dec      = w_pending && !w_start_e && w_busy;

    md_shadow_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_val_i (w_load_val),
        .load_i     (w_load),
        .dec_i      (w_dec),
        .cnt_o      (w_cnt),
        .busy_o     (w_busy)
    );

    assign w_start_mismatch = (md_start_i != w_start_e);
    assign w_busy_mismatch  = (md_busy_i  != w_pending);
    assign w_start_in_run   = w_start_e && w_pending;

    // Shadow FSM plus the sticky protocol checker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start_e) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // The timer-empty term only guards against a desync;
                    // normally the window ends on the last count.
                    if (!w_start_e && (w_last || !w_busy)) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (w_start_mismatch || w_busy_mismatch || w_start_in_run) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // Outputs are forced quiet for the whole reset cycle so D is never
    // held by a window that the reset edge is about to cancel.
    assign md_pending_o = w_pending && !reset;
    assign stall_d_o    = !reset && (d_hilo_op_i != NOP_OP) &&
                          (w_start_e || w_pending);
    assign proto_err_o  = proto_err_q;

endmodule : md_issue_ctrl
`default_nettype wire
